// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, stalls the pipeline
// while busy and strobes div_validE for one cycle when HI/LO are written.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] opaE,
    input  logic [WIDTH-1:0] opbE,
    input  logic             annulE,
    output logic             stall_divE,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_validE
);

    localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

    stateT            stateQ, stateD;
    logic [CntW-1:0]  cntQ;
    logic [WIDTH-1:0] remQ, quoQ, divisorQ;
    logic             qNegQ, rNegQ;
    logic [WIDTH-1:0] hiQ, loQ;

    logic             accept;
    logic             lastStep;
    logic             divZero;
    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH:0]   remShift, diff;
    logic [WIDTH-1:0] stepRem, stepQuo;
    logic [WIDTH-1:0] quoFinal, remFinal;

    assign accept   = (stateQ == StIdle) && startE && !annulE;
    assign lastStep = (cntQ == CntW'(WIDTH - 1));
    assign divZero  = (opbE == '0);
    assign magA     = (signedE && opaE[WIDTH-1]) ? (~opaE + 1'b1) : opaE;
    assign magB     = (signedE && opbE[WIDTH-1]) ? (~opbE + 1'b1) : opbE;

    // Restoring step: the dividend shifts out of quoQ into the partial remainder while quotient
    // bits shift in at the bottom. Bit WIDTH of diff is the borrow.
    always_comb begin
        remShift = {remQ, quoQ[WIDTH-1]};
        diff     = remShift - {1'b0, divisorQ};
        stepRem  = remShift[WIDTH-1:0];
        stepQuo  = {quoQ[WIDTH-2:0], ~diff[WIDTH]};
        if (!diff[WIDTH]) begin
            stepRem = diff[WIDTH-1:0];
        end
        quoFinal = qNegQ ? (~stepQuo + 1'b1) : stepQuo;
        remFinal = rNegQ ? (~stepRem + 1'b1) : stepRem;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (accept) begin
                    stateD = divZero ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (annulE) begin
                    stateD = StIdle;
                end else if (lastStep) begin
                    stateD = StDone;
                end
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        stall_divE = 1'b0;
        div_validE = 1'b0;
        unique case (stateQ)
            StIdle:  stall_divE = startE && !annulE;
            StBusy:  stall_divE = 1'b1;
            StDone:  div_validE = !annulE;
            default: ;
        endcase
    end

    // Datapath; HI/LO only change on entry to DONE so partial iterates never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntQ     <= '0;
            remQ     <= '0;
            quoQ     <= '0;
            divisorQ <= '0;
            qNegQ    <= 1'b0;
            rNegQ    <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
        end else if (accept) begin
            cntQ     <= '0;
            remQ     <= '0;
            quoQ     <= magA;
            divisorQ <= magB;
            qNegQ    <= signedE && (opaE[WIDTH-1] ^ opbE[WIDTH-1]);
            rNegQ    <= signedE && opaE[WIDTH-1];
            if (divZero) begin
                hiQ <= opaE;
                loQ <= '1;
            end
        end else if (stateQ == StBusy && !annulE) begin
            cntQ <= cntQ + 1'b1;
            remQ <= stepRem;
            quoQ <= stepQuo;
            if (lastStep) begin
                hiQ <= remFinal;
                loQ <= quoFinal;
            end
        end
    end

    assign hi_o = hiQ;
    assign lo_o = loQ;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (WIDTH = 32): latency, sign handling,
// overflow, divide by zero, annul in BUSY/DONE/IDLE and asynchronous reset.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startE = 1'b0;
    logic        signedE = 1'b0;
    logic [31:0] opaE = '0;
    logic [31:0] opbE = '0;
    logic        annulE = 1'b0;
    logic        stall_divE;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_validE;

    int errors = 0;
    int checks = 0;

    logic [31:0] prevLo, prevHi;
    logic        ok;

    div_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .startE     (startE),
        .signedE    (signedE),
        .opaE       (opaE),
        .opbE       (opbE),
        .annulE     (annulE),
        .stall_divE (stall_divE),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_validE (div_validE)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Each cycle begins 1 time unit after the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Start a divide in the current cycle and follow it to DONE and one cycle beyond.
    task automatic runDiv(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expLo,
                          input logic [31:0] expHi);
        logic busyOk;
        startE = 1'b1; signedE = s; opaE = a; opbE = b; annulE = 1'b0;
        #1;
        chk({tag, "_stallT"}, 32'(stall_divE), 32'd1);
        nextCycle();
        // Operands must be ignored once accepted.
        startE = 1'b0; signedE = ~s; opaE = $urandom; opbE = $urandom;
        if (b != 32'd0) begin
            busyOk = 1'b1;
            for (int i = 1; i <= 32; i++) begin
                #1;
                if (stall_divE !== 1'b1 || div_validE !== 1'b0) busyOk = 1'b0;
                nextCycle();
            end
            chk({tag, "_busyStall"}, 32'(busyOk), 32'd1);
        end
        #1;
        chk({tag, "_doneStall"}, 32'(stall_divE), 32'd0);
        chk({tag, "_valid"}, 32'(div_validE), 32'd1);
        chk({tag, "_lo"}, lo_o, expLo);
        chk({tag, "_hi"}, hi_o, expHi);
        nextCycle();
        #1;
        chk({tag, "_validOff"}, 32'(div_validE), 32'd0);
        chk({tag, "_holdLo"}, lo_o, expLo);
        prevLo = expLo;
        prevHi = expHi;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_stall", 32'(stall_divE), 32'd0);
        chk("rst_valid", 32'(div_validE), 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        runDiv("u100d7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        runDiv("sM7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        runDiv("s7dM2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        runDiv("sM100dM7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        runDiv("sOvf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        runDiv("uOvfOps", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        runDiv("uMaxd1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        runDiv("uDiv0", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234);
        runDiv("sDiv0", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0);

        // Annul in BUSY at T+10, restart at T+12
        startE = 1'b1; signedE = 1'b0; opaE = 32'd100; opbE = 32'd7;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nextCycle();
            startE = 1'b0;
            #1;
            if (div_validE !== 1'b0) ok = 1'b0;
        end
        annulE = 1'b1;
        #1;
        chk("annBusy_noValidBefore", 32'(ok), 32'd1);
        chk("annBusy_stallT10", 32'(stall_divE), 32'd1);
        nextCycle();
        annulE = 1'b0;
        #1;
        chk("annBusy_stallT11", 32'(stall_divE), 32'd0);
        chk("annBusy_valid", 32'(div_validE), 32'd0);
        chk("annBusy_lo", lo_o, prevLo);
        chk("annBusy_hi", hi_o, prevHi);
        nextCycle();
        runDiv("u9d3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Annul in DONE: no strobe, back to IDLE
        startE = 1'b1; signedE = 1'b0; opaE = 32'd50; opbE = 32'd0;
        nextCycle();
        startE = 1'b0; annulE = 1'b1;
        #1;
        chk("annDone_valid", 32'(div_validE), 32'd0);
        // start + annul together while IDLE: ignored
        nextCycle();
        startE = 1'b1; annulE = 1'b1; opaE = 32'd77; opbE = 32'd5;
        #1;
        chk("annIdle_stall", 32'(stall_divE), 32'd0);
        nextCycle();
        startE = 1'b0; annulE = 1'b0;
        #1;
        chk("annIdle_stallAfter", 32'(stall_divE), 32'd0);
        chk("annIdle_valid", 32'(div_validE), 32'd0);
        nextCycle();

        // Asynchronous reset mid-divide
        startE = 1'b1; signedE = 1'b1; opaE = 32'hFFFF_FF00; opbE = 32'd3;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            startE = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("rstMid_stall", 32'(stall_divE), 32'd0);
        chk("rstMid_valid", 32'(div_validE), 32'd0);
        chk("rstMid_hi", hi_o, 32'd0);
        chk("rstMid_lo", lo_o, 32'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        runDiv("b2b_a", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10);
        runDiv("b2b_b", 1'b1, 32'hFFFF_FC18, 32'd33, 32'hFFFF_FFE2, 32'hFFFF_FFF6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
